rv32i_wb_ctrl: RTL and testbench

Writeback controller driving the single write port (`we`/`waddr`/`wdata`) of the core's 32x32 base register file. It merges two result sources: an always-accepted ALU stream and a handshaked load-return stream buffered in a small FIFO. It also keeps a pending-load scoreboard for issue-stage stall decisions and provides a same-cycle bypass for reads that coincide with a write in flight.

---
 rtl/rv32i_wb_ctrl.sv | 131 +++++++++++++
 tb/tb_rv32i_wb_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_wb_ctrl.sv
// Writeback controller: merges ALU and buffered load results onto the
// register file write port, tracks pending loads and exposes a bypass.
module rv32i_wb_ctrl #(
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_rd,
  input  logic [31:0]                alu_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [4:0]                 ld_rd,
  input  logic [31:0]                ld_data,
  input  logic                       ld_issue,
  input  logic [4:0]                 ld_issue_rd,
  input  logic [4:0]                 q_raddr1,
  input  logic [4:0]                 q_raddr2,
  output logic                       q_busy1,
  output logic                       q_busy2,
  output logic                       byp_hit1,
  output logic                       byp_hit2,
  output logic [31:0]                byp_data,
  output logic                       alu_stall,
  output logic                       we,
  output logic [4:0]                 waddr,
  output logic [31:0]                wdata,
  output logic [$clog2(LQ_DEPTH):0]  lq_count
);

  localparam int AW = $clog2(LQ_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    q_rd  [LQ_DEPTH];
  logic [31:0]   q_dat [LQ_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic [31:0]   pend;
  logic [31:0]   pend_nxt;
  logic [SW-1:0] starve;

  logic alu_sel;
  logic enq;
  logic deq;

  assign ld_ready = cnt < (AW+1)'(LQ_DEPTH);
  assign alu_sel  = alu_valid && (alu_rd != 5'd0);
  assign enq      = ld_valid && ld_ready && (ld_rd != 5'd0);
  assign deq      = !alu_sel && (cnt != '0);

  // Clear from the drained head first so a same-cycle issue wins.
  always_comb begin
    pend_nxt = pend;
    if (deq)
      pend_nxt[q_rd[rp]] = 1'b0;
    if (ld_issue && (ld_issue_rd != 5'd0))
      pend_nxt[ld_issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_rd[wp]  <= ld_rd;
      q_dat[wp] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      pend <= '0;
    end else begin
      pend <= pend_nxt;
      if (enq)
        wp <= wp + 1'b1;
      if (deq)
        rp <= rp + 1'b1;
      unique case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we    <= 1'b0;
      waddr <= 5'd0;
      wdata <= 32'd0;
    end else begin
      we <= alu_sel || deq;
      if (alu_sel) begin
        waddr <= alu_rd;
        wdata <= alu_data;
      end else if (deq) begin
        waddr <= q_rd[rp];
        wdata <= q_dat[rp];
      end
    end
  end

  // Stall lands one cycle after the STARVE_MAX-th undrained cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve    <= '0;
      alu_stall <= 1'b0;
    end else if ((cnt == '0) || deq) begin
      starve    <= '0;
      alu_stall <= 1'b0;
    end else if (starve == SW'(STARVE_MAX - 1)) begin
      starve    <= '0;
      alu_stall <= 1'b1;
    end else begin
      starve    <= starve + 1'b1;
      alu_stall <= 1'b0;
    end
  end

  assign q_busy1  = pend[q_raddr1];
  assign q_busy2  = pend[q_raddr2];
  assign byp_hit1 = we && (waddr == q_raddr1) && (q_raddr1 != 5'd0);
  assign byp_hit2 = we && (waddr == q_raddr2) && (q_raddr2 != 5'd0);
  assign byp_data = wdata;
  assign lq_count = cnt;

endmodule

// File: tb/tb_rv32i_wb_ctrl.sv
// Scoreboard bench for rv32i_wb_ctrl: queue-based reference model,
// directed scenarios plus randomized traffic.
module tb_rv32i_wb_ctrl;

  localparam int LQ   = 2;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rstn;
  logic alu_valid;
  logic [4:0] alu_rd;
  logic [31:0] alu_data;
  logic ld_valid;
  logic ld_ready;
  logic [4:0] ld_rd;
  logic [31:0] ld_data;
  logic ld_issue;
  logic [4:0] ld_issue_rd;
  logic [4:0] q_raddr1;
  logic [4:0] q_raddr2;
  logic q_busy1;
  logic q_busy2;
  logic byp_hit1;
  logic byp_hit2;
  logic [31:0] byp_data;
  logic alu_stall;
  logic we;
  logic [4:0] waddr;
  logic [31:0] wdata;
  logic [$clog2(LQ):0] lq_count;

  rv32i_wb_ctrl #(.LQ_DEPTH(LQ), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rstn(rstn),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .q_raddr1(q_raddr1), .q_raddr2(q_raddr2),
    .q_busy1(q_busy1), .q_busy2(q_busy2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data(byp_data),
    .alu_stall(alu_stall),
    .we(we), .waddr(waddr), .wdata(wdata), .lq_count(lq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    bit rdy;
    int cnt;
    bit b1;
    bit b2;
    bit h1;
    bit h2;
    logic [31:0] bd;
    bit wen;
    bit st;
  } st_t;

  st_t sq[$];
  wr_t wq[$];

  // reference model state
  wr_t         m_q[$];
  bit  [31:0]  m_pend;
  int          m_starve;
  bit          m_stall;
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend = '0;
    m_starve = 0;
    m_stall = 1'b0;
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  // One cycle: entered and left at posedge+1.
  task automatic cyc(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                     input bit lv, input logic [4:0] lrd, input logic [31:0] ldd,
                     input bit iss, input logic [4:0] ird,
                     input logic [4:0] r1, input logic [4:0] r2,
                     output bit acc);
    st_t s;
    wr_t h;
    bit a_sel;
    bit dq;
    int n0;
    av = av && !m_stall;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd;
    ld_issue = iss; ld_issue_rd = ird;
    q_raddr1 = r1; q_raddr2 = r2;
    n0 = m_q.size();
    s.rdy = n0 < LQ;
    s.cnt = n0;
    s.b1 = (r1 != 0) && m_pend[r1];
    s.b2 = (r2 != 0) && m_pend[r2];
    s.h1 = m_we && m_wa == r1 && r1 != 0;
    s.h2 = m_we && m_wa == r2 && r2 != 0;
    s.bd = m_wd;
    s.wen = m_we;
    s.st = m_stall;
    sq.push_back(s);
    acc = lv && (n0 < LQ);
    a_sel = av && ard != 0;
    dq = !a_sel && n0 > 0;
    if (a_sel) begin
      m_we = 1'b1; m_wa = ard; m_wd = ad;
    end else if (dq) begin
      h = m_q.pop_front();
      m_we = 1'b1; m_wa = h.rd; m_wd = h.d;
      m_pend[h.rd] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (a_sel || dq) wq.push_back('{m_wa, m_wd});
    if (acc && lrd != 0) m_q.push_back('{lrd, ldd});
    if (iss && ird != 0) m_pend[ird] = 1'b1;
    if (n0 == 0 || dq) begin
      m_starve = 0;
      m_stall = 1'b0;
    end else begin
      m_starve++;
      m_stall = (m_starve == SMAX);
      if (m_stall) m_starve = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++)
      cyc(0, 0, 0, 0, 0, 0, 0, 0, q_raddr1, q_raddr2, a);
  endtask

  // monitor: per-cycle status and write-port scoreboard
  initial begin
    st_t s;
    wr_t w;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (sq.size() != 0) begin
          s = sq.pop_front();
          chk("ld_ready", ld_ready, s.rdy);
          chk("lq_count", lq_count, s.cnt);
          chk("q_busy1", q_busy1, s.b1);
          chk("q_busy2", q_busy2, s.b2);
          chk("byp_hit1", byp_hit1, s.h1);
          chk("byp_hit2", byp_hit2, s.h2);
          chk("alu_stall", alu_stall, s.st);
          chk("we", we, s.wen);
          if (s.h1 || s.h2) chk("byp_data", byp_data, s.bd);
        end
        if (we) begin
          chk("write_expected", wq.size() != 0, 1);
          if (wq.size() != 0) begin
            w = wq.pop_front();
            chk("waddr", waddr, w.rd);
            chk("wdata", wdata, w.d);
          end
        end
      end
    end
  end

  initial begin
    bit a;
    bit hv;
    logic [4:0] hrd;
    logic [31:0] hd;
    int k;
    int st_at;
    rstn = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    q_raddr1 = 0; q_raddr2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_lq_count", lq_count, 0);
    chk("rst_alu_stall", alu_stall, 0);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;

    // traffic, then asynchronous reset mid-stream
    cyc(1, 2, 32'h1, 1, 12, 32'hAA, 1, 12, 12, 0, a);
    cyc(1, 3, 32'h2, 1, 13, 32'hBB, 0, 0, 12, 0, a);
    rstn = 1'b0;
    alu_valid = 0; ld_valid = 0; ld_issue = 0;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_lq_count", lq_count, 0);
    chk("mid_rst_ld_ready", ld_ready, 1);
    chk("mid_rst_q_busy1", q_busy1, 0);
    sq.delete();
    wq.delete();
    model_reset();
    @(negedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, a);
    chk("alu_we", we, 1);
    chk("alu_waddr", waddr, 5);
    chk("alu_wdata", wdata, 32'hDEADBEEF);

    // priority: ALU first, load next cycle
    idle(2);
    cyc(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0, a);
    chk("prio_acc", a, 1);
    chk("prio_alu_waddr", waddr, 3);
    idle(1);
    chk("prio_ld_waddr", waddr, 4);
    chk("prio_ld_wdata", wdata, 32'h22);
    chk("prio_lq_count", lq_count, 0);
    idle(2);

    // FIFO full with ALU hogging the port
    cyc(1, 1, 32'h100, 1, 6, 32'h66, 0, 0, 0, 0, a);
    cyc(1, 1, 32'h101, 1, 7, 32'h77, 0, 0, 0, 0, a);
    chk("full_ld_ready", ld_ready, 0);
    k = 0;
    a = 0;
    while (!a && k < 12) begin
      cyc(1, 1, 32'h200 + k, 1, 8, 32'h88, 0, 0, 0, 0, a);
      k++;
    end
    chk("full_third_accepted", a, 1);
    idle(6);

    // starvation: one queued load, ALU every cycle
    cyc(1, 1, 32'h300, 1, 10, 32'hA0A0, 0, 0, 0, 0, a);
    st_at = 0;
    for (int i = 1; i <= 10 && st_at == 0; i++) begin
      if (alu_stall) st_at = i;
      cyc(1, 1, 32'h300 + i, 0, 0, 0, 0, 0, 0, 0, a);
    end
    chk("starve_cycle", st_at, 5);
    chk("starve_ld_we", we, 1);
    chk("starve_ld_waddr", waddr, 10);
    idle(3);

    // scoreboard and bypass on x9
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, a);
    chk("sb_busy_rise", q_busy1, 1);
    idle(2);
    chk("sb_busy_hold", q_busy1, 1);
    cyc(0, 0, 0, 1, 9, 32'hCAFE0009, 0, 0, 9, 0, a);
    chk("sb_busy_deq", q_busy1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, a);
    chk("sb_byp_hit1", byp_hit1, 1);
    chk("sb_byp_data", byp_data, 32'hCAFE0009);
    chk("sb_busy_clear", q_busy1, 0);
    idle(2);

    // x0 handling
    cyc(1, 0, 32'h5555, 1, 0, 32'h6666, 1, 0, 0, 0, a);
    chk("x0_ld_acc", a, 1);
    chk("x0_we", we, 0);
    chk("x0_lq_count", lq_count, 0);
    chk("x0_busy", q_busy1, 0);
    idle(1);
    chk("x0_we_after", we, 0);

    // randomized traffic
    hv = 0;
    hrd = 0;
    hd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hv && ($urandom % 2 == 1)) begin
        hv = 1;
        hrd = 5'($urandom_range(0, 7));
        hd = $urandom;
      end
      cyc($urandom % 3 == 0, 5'($urandom_range(0, 7)), $urandom,
          hv, hrd, hd,
          $urandom % 4 == 0, 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), a);
      if (a) hv = 0;
    end
    idle(8);
    chk("wq_drained", wq.size(), 0);
    chk("lq_empty", lq_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
